// File: rtl/cpu_pkg.sv
// Shared types and constants for the 3-stage MIPS pipeline.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_RA_W   = 5;

  // ALU operation codes produced by the decode/control unit
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_MULT  = 4'b0110;
  localparam logic [3:0] OP_MULTU = 4'b0111;

  // Register-file write-back source; code 3 also selects the ALU result
  typedef enum logic [1:0] {
    SEL_ALU     = 2'd0,
    SEL_HI      = 2'd1,
    SEL_LO      = 2'd2,
    SEL_ALU_ALT = 2'd3
  } regsel_e;

  // Sequential multiplier control states
  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_BUSY = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, signed
// operands handled as magnitudes with the sign re-applied to the result.
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  mult_state_e         state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic                neg_q, neg_d;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] acc_step;

  // Operand magnitudes, the next accumulator value and the signed result
  always_comb begin
    a_mag    = (is_signed && a[DATA_W-1]) ? -a : a;
    b_mag    = (is_signed && b[DATA_W-1]) ? -b : b;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    product  = neg_q ? -acc_step : acc_step;
  end

  // Next-state logic; busy is gated by reset so the stall drops at once
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      MULT_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          mcand_d  = {{DATA_W{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = MULT_BUSY;
        end
      end
      MULT_BUSY: begin
        busy     = 1'b1;
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          done    = 1'b1;
          state_d = MULT_DONE;
        end
      end
      MULT_DONE: state_d = MULT_IDLE;
      default:   state_d = MULT_IDLE;
    endcase
    if (rst) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MULT_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX-to-WB stage: write-back register, HI/LO with sequential multiply,
// EX/fetch stall while multiplying, and the GPIO output register.
module ex_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int RA_W   = CPU_RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        op_EX,
  input  logic              enhilo_EX,
  input  logic [1:0]        regsel_EX,
  input  logic              regwrite_EX,
  input  logic              rdrt_EX,
  input  logic [RA_W-1:0]   rd_EX,
  input  logic [RA_W-1:0]   rt_EX,
  input  logic [DATA_W-1:0] rs_data_EX,
  input  logic [DATA_W-1:0] rt_data_EX,
  input  logic [DATA_W-1:0] alu_result_EX,
  input  logic              gpio_out_en_EX,
  output logic              stall_EX,
  output logic              regwrite_WB,
  output logic [RA_W-1:0]   regdest_WB,
  output logic [DATA_W-1:0] writedata_WB,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DATA_W-1:0] gpio_out
);

  logic                mult_busy, mult_done;
  logic [2*DATA_W-1:0] mult_product;

  logic [DATA_W-1:0]   hi_d, lo_d, gpio_d;
  logic                regwrite_wb_d;
  logic [RA_W-1:0]     regdest_wb_d;
  logic [DATA_W-1:0]   writedata_wb_d;
  logic [RA_W-1:0]     dest_ex;
  logic [DATA_W-1:0]   wb_src;

  seq_multiplier #(.DATA_W(DATA_W)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (enhilo_EX),
    .is_signed (op_EX == OP_MULT),
    .a         (rs_data_EX),
    .b         (rt_data_EX),
    .busy      (mult_busy),
    .done      (mult_done),
    .product   (mult_product)
  );

  assign stall_EX = mult_busy;

  // Next values for HI/LO, the WB register (bubble on stall) and GPIO
  always_comb begin
    dest_ex = rdrt_EX ? rt_EX : rd_EX;
    case (regsel_EX)
      SEL_HI:  wb_src = hi_q;
      SEL_LO:  wb_src = lo_q;
      default: wb_src = alu_result_EX;
    endcase

    hi_d = hi_q;
    lo_d = lo_q;
    if (mult_done) begin
      {hi_d, lo_d} = mult_product;
    end

    regwrite_wb_d  = 1'b0;
    regdest_wb_d   = regdest_WB;
    writedata_wb_d = writedata_WB;
    if (!stall_EX) begin
      regdest_wb_d   = dest_ex;
      writedata_wb_d = wb_src;
      regwrite_wb_d  = regwrite_EX & ~enhilo_EX & (dest_ex != '0);
    end

    gpio_d = gpio_out;
    if (gpio_out_en_EX && !stall_EX) begin
      gpio_d = rt_data_EX;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q         <= '0;
      lo_q         <= '0;
      regwrite_WB  <= 1'b0;
      regdest_WB   <= '0;
      writedata_WB <= '0;
      gpio_out     <= '0;
    end else begin
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      regwrite_WB  <= regwrite_wb_d;
      regdest_WB   <= regdest_wb_d;
      writedata_WB <= writedata_wb_d;
      gpio_out     <= gpio_d;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: expected write-backs are queued when an
// instruction is driven and popped when regwrite_WB is seen.
module tb_ex_wb_stage;
  import cpu_pkg::*;

  localparam int STALL_CYCLES = 33;

  logic        clk;
  logic        rst;
  logic [3:0]  op_EX;
  logic        enhilo_EX;
  logic [1:0]  regsel_EX;
  logic        regwrite_EX;
  logic        rdrt_EX;
  logic [4:0]  rd_EX;
  logic [4:0]  rt_EX;
  logic [31:0] rs_data_EX;
  logic [31:0] rt_data_EX;
  logic [31:0] alu_result_EX;
  logic        gpio_out_en_EX;
  logic        stall_EX;
  logic        regwrite_WB;
  logic [4:0]  regdest_WB;
  logic [31:0] writedata_WB;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] gpio_out;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  ex_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .op_EX          (op_EX),
    .enhilo_EX      (enhilo_EX),
    .regsel_EX      (regsel_EX),
    .regwrite_EX    (regwrite_EX),
    .rdrt_EX        (rdrt_EX),
    .rd_EX          (rd_EX),
    .rt_EX          (rt_EX),
    .rs_data_EX     (rs_data_EX),
    .rt_data_EX     (rt_data_EX),
    .alu_result_EX  (alu_result_EX),
    .gpio_out_en_EX (gpio_out_en_EX),
    .stall_EX       (stall_EX),
    .regwrite_WB    (regwrite_WB),
    .regdest_WB     (regdest_WB),
    .writedata_WB   (writedata_WB),
    .hi_q           (hi_q),
    .lo_q           (lo_q),
    .gpio_out       (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product computed directly with 64-bit arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic nop_inputs();
    op_EX = OP_ADD; enhilo_EX = 1'b0; regsel_EX = 2'd0; regwrite_EX = 1'b0;
    rdrt_EX = 1'b0; rd_EX = '0; rt_EX = '0; rs_data_EX = '0; rt_data_EX = '0;
    alu_result_EX = '0; gpio_out_en_EX = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a mult/multu (with a stray regwrite) and wait for it to retire
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         output int cyc, output bit we_seen);
    rs_data_EX = a; rt_data_EX = b; op_EX = sgn ? OP_MULT : OP_MULTU;
    enhilo_EX = 1'b1; regwrite_EX = 1'b1; rd_EX = 5'd3; rdrt_EX = 1'b0;
    regsel_EX = 2'd0; alu_result_EX = 32'hBAD0BAD0;
    cyc = 0; we_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (regwrite_WB) we_seen = 1'b1;
      if (!stall_EX) break;
      cyc++;
    end
    tick();
    if (regwrite_WB) we_seen = 1'b1;
    nop_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nop_inputs();
    #12;
    n_cmp++; if (stall_EX !== 1'b0) begin n_err++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_EX); end
    n_cmp++; if (regwrite_WB !== 1'b0) begin n_err++; $display("[TB] FAIL reset_regwrite: got %b expected 0", regwrite_WB); end
    n_cmp++; if (regdest_WB !== 5'd0) begin n_err++; $display("[TB] FAIL reset_regdest: got %0d expected 0", regdest_WB); end
    n_cmp++; if (writedata_WB !== 32'd0) begin n_err++; $display("[TB] FAIL reset_writedata: got %h expected 0", writedata_WB); end
    n_cmp++; if (hi_q !== 32'd0) begin n_err++; $display("[TB] FAIL reset_hi: got %h expected 0", hi_q); end
    n_cmp++; if (lo_q !== 32'd0) begin n_err++; $display("[TB] FAIL reset_lo: got %h expected 0", lo_q); end
    n_cmp++; if (gpio_out !== 32'd0) begin n_err++; $display("[TB] FAIL reset_gpio: got %h expected 0", gpio_out); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    // rdrt, rd, rt, regsel, regwrite, alu result
    logic        t_rdrt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0]  t_rd[5]   = '{5'd7, 5'd7, 5'd12, 5'd0, 5'd9};
    logic [4:0]  t_rt[5]   = '{5'd5, 5'd0, 5'd3, 5'd4, 5'd2};
    logic [1:0]  t_sel[5]  = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
    logic        t_we[5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_alu[5]  = '{32'h00001234, 32'h00001234, 32'hDEADBEEF, 32'h11111111, 32'h22222222};
    wb_exp_t e;
    for (int i = 0; i < 5; i++) begin
      nop_inputs();
      rdrt_EX = t_rdrt[i]; rd_EX = t_rd[i]; rt_EX = t_rt[i];
      regsel_EX = t_sel[i]; regwrite_EX = t_we[i]; alu_result_EX = t_alu[i];
      e.dest = t_rdrt[i] ? t_rt[i] : t_rd[i];
      e.data = t_alu[i];
      if (t_we[i] && e.dest != 5'd0) sb_q.push_back(e);
      tick();
      n_cmp++;
      if (regwrite_WB) begin
        if (sb_q.size() == 0) begin
          n_err++; $display("[TB] FAIL alu_wb[%0d]: got write $%0d=%h expected no write", i, regdest_WB, writedata_WB);
        end else begin
          e = sb_q.pop_front();
          if (regdest_WB !== e.dest || writedata_WB !== e.data) begin
            n_err++; $display("[TB] FAIL alu_wb[%0d]: got $%0d=%h expected $%0d=%h", i, regdest_WB, writedata_WB, e.dest, e.data);
          end
        end
      end else if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_err++; $display("[TB] FAIL alu_wb[%0d]: got no write expected $%0d=%h", i, e.dest, e.data);
      end
    end
    nop_inputs();
    tick();
  endtask

  task automatic test_gpio();
    gpio_out_en_EX = 1'b1; rt_data_EX = 32'hA5A5A5A5;
    tick();
    n_cmp++; if (gpio_out !== 32'hA5A5A5A5) begin n_err++; $display("[TB] FAIL gpio_write: got %h expected a5a5a5a5", gpio_out); end
    nop_inputs();
    tick();
    op_EX = OP_MULTU; enhilo_EX = 1'b1; rs_data_EX = 32'd1;
    gpio_out_en_EX = 1'b1; rt_data_EX = 32'h5A5A5A5A;
    tick();
    n_cmp++; if (gpio_out !== 32'hA5A5A5A5) begin n_err++; $display("[TB] FAIL gpio_stalled: got %h expected a5a5a5a5", gpio_out); end
    gpio_out_en_EX = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_EX) break;
    end
    tick();
    nop_inputs();
    tick();
  endtask

  task automatic test_mult_signed();
    int cyc; bit we; logic [63:0] p;
    p = ref_mul(32'hFFFFFFFF, 32'h00000001, 1'b1);
    do_mult(32'hFFFFFFFF, 32'h00000001, 1'b1, cyc, we);
    n_cmp++; if (cyc != STALL_CYCLES) begin n_err++; $display("[TB] FAIL mult_stall_cycles: got %0d expected %0d", cyc, STALL_CYCLES); end
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("[TB] FAIL mult_no_regwrite: got %b expected 0", we); end
    n_cmp++; if (hi_q !== p[63:32]) begin n_err++; $display("[TB] FAIL mult_hi: got %h expected %h", hi_q, p[63:32]); end
    n_cmp++; if (lo_q !== p[31:0]) begin n_err++; $display("[TB] FAIL mult_lo: got %h expected %h", lo_q, p[31:0]); end
    tick();
  endtask

  task automatic test_mfhi_mflo();
    int cyc; bit we; logic [63:0] p; wb_exp_t e;
    p = ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, we);
    n_cmp++; if (cyc != STALL_CYCLES) begin n_err++; $display("[TB] FAIL multu_stall_cycles: got %0d expected %0d", cyc, STALL_CYCLES); end
    for (int i = 0; i < 2; i++) begin
      nop_inputs();
      regwrite_EX = 1'b1; rd_EX = (i == 0) ? 5'd8 : 5'd9;
      regsel_EX = (i == 0) ? SEL_HI : SEL_LO;
      alu_result_EX = 32'h0BADF00D;
      e.dest = rd_EX;
      e.data = (i == 0) ? p[63:32] : p[31:0];
      sb_q.push_back(e);
      tick();
      n_cmp++;
      if (regwrite_WB !== 1'b1 || sb_q.size() == 0) begin
        n_err++; $display("[TB] FAIL mf_wb[%0d]: got regwrite %b expected 1", i, regwrite_WB);
      end else begin
        e = sb_q.pop_front();
        if (regdest_WB !== e.dest || writedata_WB !== e.data) begin
          n_err++; $display("[TB] FAIL mf_wb[%0d]: got $%0d=%h expected $%0d=%h", i, regdest_WB, writedata_WB, e.dest, e.data);
        end
      end
    end
    nop_inputs();
    tick();
    n_cmp++; if (regwrite_WB !== 1'b0) begin n_err++; $display("[TB] FAIL mf_after_nop: got %b expected 0", regwrite_WB); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit we; logic [63:0] p;
    tick();
    p = ref_mul(32'h80000000, 32'h80000000, 1'b1);
    do_mult(32'h80000000, 32'h80000000, 1'b1, cyc, we);
    n_cmp++; if ({hi_q, lo_q} !== p) begin n_err++; $display("[TB] FAIL mult_minint: got %h%h expected %h", hi_q, lo_q, p); end
    p = ref_mul(32'd7, 32'hFFFFFFFD, 1'b1);
    do_mult(32'd7, 32'hFFFFFFFD, 1'b1, cyc, we);
    n_cmp++; if (cyc != STALL_CYCLES) begin n_err++; $display("[TB] FAIL b2b_stall_cycles: got %0d expected %0d", cyc, STALL_CYCLES); end
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_no_regwrite: got %b expected 0", we); end
    n_cmp++; if ({hi_q, lo_q} !== p) begin n_err++; $display("[TB] FAIL b2b_product: got %h%h expected %h", hi_q, lo_q, p); end
    tick();
  endtask

  task automatic test_reset_mid_mult();
    int cyc; bit we;
    op_EX = OP_MULTU; enhilo_EX = 1'b1; rs_data_EX = 32'h12345678; rt_data_EX = 32'd9;
    repeat (10) tick();
    #2;
    n_cmp++; if (stall_EX !== 1'b1) begin n_err++; $display("[TB] FAIL midmult_stall: got %b expected 1", stall_EX); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stall_EX !== 1'b0) begin n_err++; $display("[TB] FAIL async_rst_stall: got %b expected 0", stall_EX); end
    n_cmp++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin n_err++; $display("[TB] FAIL async_rst_hilo: got %h/%h expected 0/0", hi_q, lo_q); end
    nop_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_mult(32'd3, 32'd4, 1'b0, cyc, we);
    n_cmp++; if (cyc != STALL_CYCLES) begin n_err++; $display("[TB] FAIL post_rst_stall_cycles: got %0d expected %0d", cyc, STALL_CYCLES); end
    n_cmp++; if (lo_q !== 32'd12 || hi_q !== 32'd0) begin n_err++; $display("[TB] FAIL post_rst_mult: got %h/%h expected 0/c", hi_q, lo_q); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_gpio();
    test_mult_signed();
    test_mfhi_mflo();
    test_back_to_back();
    test_reset_mid_mult();
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
